// File: rtl/kbd_event_queue.sv
// PS/2 byte fetch, scan-code prefix decode, held-key tracking and show-ahead event FIFO.
// Optional KBD_REPEAT_FILTER_EN suppresses typematic repeats of the held key.
module kbd_event_queue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_ready,
  input  logic             kbd_overflow,
  output logic             nextdata_n,
  output logic             evt_valid,
  output logic [9:0]       evt_data,
  input  logic             evt_pop,
  output logic [OW-1:0]    evt_count,
  output logic             key_held,
  output logic [7:0]       held_code,
  output logic [CNT_W-1:0] key_cnt,
  output logic [7:0]       drop_cnt,
  output logic             err
);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_GAP} state_t;

  localparam logic [OW-1:0] FULL_CNT = OW'(DEPTH);

  state_t           state_q;
  logic [7:0]       byte_q;
  logic             ext_q, brk_q;
  logic             nextdata_n_q;
  logic             pend_vld_q;
  logic [9:0]       pend_evt_q;

  logic             key_held_q, held_ext_q;
  logic [7:0]       held_code_q;
  logic [CNT_W-1:0] key_cnt_q;
  logic [7:0]       drop_cnt_q;
  logic             err_q;

  logic [9:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]    count_q;

  logic             dec_vld;
  logic             p_ext, p_brk;
  logic [7:0]       p_code;
  logic             match, filt, push, pop_ok, wr_ok;

  // Prefix bytes and the 00/FF error codes never produce an event.
  always_comb begin
    dec_vld = 1'b0;
    if (state_q == S_ACK && byte_q != 8'hE0 && byte_q != 8'hF0 &&
        byte_q != 8'h00 && byte_q != 8'hFF)
      dec_vld = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      byte_q       <= 8'h00;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      nextdata_n_q <= 1'b1;
      pend_vld_q   <= 1'b0;
      pend_evt_q   <= 10'h000;
    end else begin
      pend_vld_q <= 1'b0;
      case (state_q)
        S_IDLE: if (kbd_ready) begin
          byte_q       <= kbd_data;
          nextdata_n_q <= 1'b0;
          state_q      <= S_ACK;
        end
        S_ACK: begin
          nextdata_n_q <= 1'b1;
          state_q      <= S_GAP;
          case (byte_q)
            8'hE0:   ext_q <= 1'b1;
            8'hF0:   brk_q <= 1'b1;
            default: begin
              ext_q <= 1'b0;
              brk_q <= 1'b0;
            end
          endcase
          if (dec_vld) begin
            pend_vld_q <= 1'b1;
            pend_evt_q <= {ext_q, brk_q, byte_q};
          end
        end
        S_GAP:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign p_ext  = pend_evt_q[9];
  assign p_brk  = pend_evt_q[8];
  assign p_code = pend_evt_q[7:0];
  assign match  = key_held_q && (held_ext_q == p_ext) && (held_code_q == p_code);
`ifdef KBD_REPEAT_FILTER_EN
  assign filt   = !p_brk && match;
`else
  assign filt   = 1'b0;
`endif
  assign push   = pend_vld_q && !filt;
  assign pop_ok = evt_pop && (count_q != '0);
  assign wr_ok  = push && ((count_q != FULL_CNT) || pop_ok);

  // Held-key and counters follow the event even when the FIFO drops it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      key_held_q  <= 1'b0;
      held_ext_q  <= 1'b0;
      held_code_q <= 8'h00;
      key_cnt_q   <= '0;
      drop_cnt_q  <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      if (push) begin
        if (!p_brk) begin
          key_cnt_q   <= key_cnt_q + CNT_W'(1);
          key_held_q  <= 1'b1;
          held_ext_q  <= p_ext;
          held_code_q <= p_code;
        end else if (match) begin
          key_held_q <= 1'b0;
        end
      end
      if (push && !wr_ok && drop_cnt_q != 8'hFF)
        drop_cnt_q <= drop_cnt_q + 8'd1;
      if (kbd_overflow)
        err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok)  wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_ok, pop_ok})
        2'b10:   count_q <= count_q + OW'(1);
        2'b01:   count_q <= count_q - OW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= pend_evt_q;
  end

  assign nextdata_n = nextdata_n_q;
  assign evt_valid  = (count_q != '0);
  assign evt_data   = (count_q != '0) ? mem_q[rd_ptr_q] : 10'h000;
  assign evt_count  = count_q;
  assign key_held   = key_held_q;
  assign held_code  = held_code_q;
  assign key_cnt    = key_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_kbd_event_queue.sv
// Directed bench for kbd_event_queue: queue-based reference model compared every cycle,
// plus literal expectations for the documented byte sequences.
module tb_kbd_event_queue;
  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
  localparam int OW    = $clog2(DEPTH + 1);

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic [7:0]       kbd_data = 8'h00;
  logic             kbd_ready = 1'b0;
  logic             kbd_overflow = 1'b0;
  logic             nextdata_n;
  logic             evt_valid;
  logic [9:0]       evt_data;
  logic             evt_pop = 1'b0;
  logic [OW-1:0]    evt_count;
  logic             key_held;
  logic [7:0]       held_code;
  logic [CNT_W-1:0] key_cnt;
  logic [7:0]       drop_cnt;
  logic             err;

  kbd_event_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
    .kbd_overflow(kbd_overflow), .nextdata_n(nextdata_n), .evt_valid(evt_valid),
    .evt_data(evt_data), .evt_pop(evt_pop), .evt_count(evt_count), .key_held(key_held),
    .held_code(held_code), .key_cnt(key_cnt), .drop_cnt(drop_cnt), .err(err)
  );

  always #5 clk_i = ~clk_i;

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model: keyboard protocol state and event queue.
  logic [9:0]       m_q [$];
  logic             m_ext, m_brk, m_held, m_hext, m_err;
  logic [7:0]       m_hcode, m_drop;
  logic [CNT_W-1:0] m_kcnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_ext = 0; m_brk = 0; m_held = 0; m_hext = 0; m_err = 0;
    m_hcode = 0; m_drop = 0; m_kcnt = 0;
  endtask

  task automatic m_push(input logic [9:0] e);
    if (m_q.size() < DEPTH) m_q.push_back(e);
    else if (m_drop != 8'hFF) m_drop++;
  endtask

  task automatic m_apply(input logic [7:0] b, input bit pop);
    logic [9:0] ev;
    bit rep, filt;
    if (pop && m_q.size() > 0) void'(m_q.pop_front());
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'h00 || b == 8'hFF) begin m_ext = 0; m_brk = 0; end
    else begin
      ev = {m_ext, m_brk, b};
      rep = m_held && (m_hext == m_ext) && (m_hcode == b);
      if (!m_brk) begin
        filt = 0;
`ifdef KBD_REPEAT_FILTER_EN
        filt = rep;
`endif
        if (!filt) begin
          m_push(ev);
          m_kcnt++;
          m_held = 1; m_hext = m_ext; m_hcode = b;
        end
      end else begin
        m_push(ev);
        if (rep) m_held = 0;
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  always @(negedge clk_i) begin
    if (chk_en && !rst_i) begin
      chk("evt_valid", evt_valid, m_q.size() != 0);
      chk("evt_data",  evt_data,  m_q.size() != 0 ? m_q[0] : 10'h000);
      chk("evt_count", evt_count, m_q.size());
      chk("key_held",  key_held,  m_held);
      chk("held_code", held_code, m_hcode);
      chk("key_cnt",   key_cnt,   m_kcnt);
      chk("drop_cnt",  drop_cnt,  m_drop);
      chk("err",       err,       m_err);
    end
  end

  // Offer a byte, wait for the acknowledge, then fold it into the model on the
  // edge where its event lands (two edges after the capture edge).
  task automatic send_byte(input logic [7:0] b, input bit pop = 0);
    bit acked = 0;
    @(negedge clk_i);
    kbd_data = b; kbd_ready = 1'b1;
    for (int i = 0; i < 10 && !acked; i++) begin
      @(negedge clk_i);
      if (!nextdata_n) acked = 1;
    end
    kbd_ready = 1'b0;
    if (!acked) chk("ack_timeout", 0, 1);
    @(negedge clk_i);
    if (pop) evt_pop = 1'b1;
    @(posedge clk_i);
    #1;
    evt_pop = 1'b0;
    m_apply(b, pop);
  endtask

  task automatic pop_expect(input logic [9:0] exp);
    @(negedge clk_i);
    chk("pop_head", evt_data, exp);
    evt_pop = 1'b1;
    @(posedge clk_i);
    #1;
    evt_pop = 1'b0;
    if (m_q.size() > 0) void'(m_q.pop_front());
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("rst_nextdata_n", nextdata_n, 1);
    chk("rst_evt_valid",  evt_valid,  0);
    chk("rst_evt_data",   evt_data,   0);
    chk("rst_evt_count",  evt_count,  0);
    chk("rst_key_held",   key_held,   0);
    chk("rst_held_code",  held_code,  0);
    chk("rst_key_cnt",    key_cnt,    0);
    chk("rst_drop_cnt",   drop_cnt,   0);
    chk("rst_err",        err,        0);
    m_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    int n_exp, n_low, last_low;
    bit acked;
    m_reset();
    repeat (2) @(negedge clk_i);
    do_reset();
    chk_en = 1'b1;

    // Make then matching break.
    send_byte(8'h1C);
    chk("lit_held_after_make", key_held, 1);
    send_byte(8'hF0); send_byte(8'h1C);
    chk("lit_kcnt_1c", key_cnt, 1);
    chk("lit_held_after_brk", key_held, 0);
    chk("lit_hcode_1c", held_code, 8'h1C);
    pop_expect(10'h01C);
    pop_expect(10'h11C);
    pop_expect(10'h000);            // pop on empty is ignored
    chk("lit_empty_count", evt_count, 0);

    // Break of a different key leaves the held key alone.
    send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h2A);
    chk("lit_held_nonmatch", key_held, 1);
    chk("lit_hcode_nonmatch", held_code, 8'h1C);
    pop_expect(10'h01C);
    pop_expect(10'h12A);

    // Extended make/break.
    do_reset();
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    chk("lit_kcnt_ext", key_cnt, 1);
    pop_expect(10'h275);
    pop_expect(10'h375);

    // Typematic repeat.
    do_reset();
    repeat (4) send_byte(8'h1C);
`ifdef KBD_REPEAT_FILTER_EN
    n_exp = 1;
`else
    n_exp = 4;
`endif
    chk("lit_rep_count", evt_count, n_exp);
    chk("lit_rep_kcnt", key_cnt, n_exp);
    for (int i = 0; i < n_exp; i++) pop_expect(10'h01C);

    // Overfill without pops.
    do_reset();
    for (int i = 0; i < 10; i++) send_byte(8'h10 + 8'(i));
    chk("lit_full_count", evt_count, 8);
    chk("lit_full_drop", drop_cnt, 2);
    chk("lit_full_kcnt", key_cnt, 10);
    for (int i = 0; i < 8; i++) pop_expect(10'h010 + 10'(i));
    chk("lit_drained", evt_valid, 0);

    // Push and pop together while full.
    do_reset();
    for (int i = 0; i < 8; i++) send_byte(8'h30 + 8'(i));
    send_byte(8'h38, 1);
    chk("lit_pp_count", evt_count, 8);
    chk("lit_pp_drop", drop_cnt, 0);
    chk("lit_pp_head", evt_data, 10'h031);

    // Drop counter saturation and key counter wrap.
    do_reset();
    for (int i = 0; i < 265; i++) send_byte((i % 2) ? 8'h41 : 8'h40);
    chk("lit_drop_sat", drop_cnt, 255);
    chk("lit_kcnt_wrap", key_cnt, 9);

    // Continuous ready: one acknowledge every third cycle; sticky overflow.
    do_reset();
    @(negedge clk_i);
    kbd_data = 8'h00; kbd_ready = 1'b1;
    n_low = 0; last_low = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (!nextdata_n) begin
        if (last_low >= 0) chk("ack_spacing", i - last_low, 3);
        last_low = i;
        n_low++;
      end
    end
    kbd_ready = 1'b0;
    chk("ack_count_30", n_low, 10);
    repeat (4) @(negedge clk_i);
    kbd_overflow = 1'b1;
    @(posedge clk_i);
    #1;
    kbd_overflow = 1'b0;
    m_err = 1;
    repeat (5) @(negedge clk_i);
    chk("lit_err_sticky", err, 1);
    do_reset();

    // Reset in the middle of acknowledging an E0 prefix.
    @(negedge clk_i);
    kbd_data = 8'hE0; kbd_ready = 1'b1;
    acked = 0;
    for (int i = 0; i < 10 && !acked; i++) begin
      @(negedge clk_i);
      if (!nextdata_n) acked = 1;
    end
    if (!acked) chk("ack_timeout_rst", 0, 1);
    #2;
    rst_i = 1'b1;
    kbd_ready = 1'b0;
    #1;
    chk("rst_in_ack_nextdata_n", nextdata_n, 1);
    m_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    send_byte(8'h75);
    pop_expect(10'h075);

    repeat (3) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
